// File: rtl/asrm_irq_ctrl.sv
// External interrupt request controller: synchronises, glitch-filters and latches
// four request pins, and presents masked pending requests to the CPU core.
module asrm_irq_ctrl #(
  parameter int                  wordsize    = 16,
  parameter logic [wordsize-1:0] BASE_ADDR   = 16'hFF00,
  parameter int                  SYNC_STAGES = 2,
  parameter int                  FILTER_LEN  = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [3:0]          irq_in,
  input  logic [wordsize-1:0] addr,
  input  logic [wordsize-1:0] bus_wdata,
  input  logic                write_en,
  output logic [wordsize-1:0] bus_rdata,
  output logic                bus_sel,
  output logic [3:0]          ext_int
);

  logic [SYNC_STAGES-1:0] sync_q [4];
  logic [3:0] synced;
  logic [3:0] filtered;
  logic [3:0] active;
  logic [3:0] active_prev;
  logic [3:0] pending;
  logic [3:0] enable;
  logic [3:0] mode;
  logic [3:0] polarity;
  logic [3:0] rd_val;
  logic [3:0] w1c;
  logic [wordsize-1:0] off;
  logic [2:0] reg_idx;
  logic wr;
  logic unused_wdata;

  assign unused_wdata = ^bus_wdata[wordsize-1:4];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) sync_q[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], irq_in[i]};
    end
  end

  always_comb begin
    synced = '0;
    for (int i = 0; i < 4; i++) synced[i] = sync_q[i][SYNC_STAGES-1];
  end

  // The filtered level only follows synced after FILTER_LEN consecutive disagreeing cycles
  if (FILTER_LEN > 0) begin : g_filter
    localparam int CW = $clog2(FILTER_LEN + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);
    logic [CW-1:0] cnt [4];
    logic [3:0] filt_q;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        filt_q <= '0;
        for (int i = 0; i < 4; i++) cnt[i] <= '0;
      end else begin
        for (int i = 0; i < 4; i++) begin
          if (synced[i] == filt_q[i]) begin
            cnt[i] <= '0;
          end else if (cnt[i] == CNT_LAST) begin
            filt_q[i] <= synced[i];
            cnt[i]    <= '0;
          end else begin
            cnt[i] <= cnt[i] + CW'(1);
          end
        end
      end
    end

    assign filtered = filt_q;
  end else begin : g_bypass
    assign filtered = synced;
  end

  assign active = filtered ^ polarity;

  assign off     = addr - BASE_ADDR;
  assign reg_idx = off[2:0];
  assign bus_sel = (addr >= BASE_ADDR) && (off <= wordsize'(4));
  assign wr      = write_en && bus_sel;
  assign w1c     = (wr && reg_idx == 3'd0) ? bus_wdata[3:0] : 4'h0;

  always_comb begin
    rd_val = 4'h0;
    if (bus_sel) begin
      case (reg_idx)
        3'd0:    rd_val = pending;
        3'd1:    rd_val = enable;
        3'd2:    rd_val = mode;
        3'd3:    rd_val = polarity;
        3'd4:    rd_val = active;
        default: rd_val = 4'h0;
      endcase
    end
    bus_rdata = {{(wordsize-4){1'b0}}, rd_val};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      enable   <= 4'h0;
      mode     <= 4'hF;
      polarity <= 4'h0;
    end else if (wr) begin
      case (reg_idx)
        3'd1:    enable   <= bus_wdata[3:0];
        3'd2:    mode     <= bus_wdata[3:0];
        3'd3:    polarity <= bus_wdata[3:0];
        default: ;
      endcase
    end
  end

  // In edge mode a new edge beats a simultaneous clear; level mode simply tracks the line
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      active_prev <= 4'h0;
      pending     <= 4'h0;
      ext_int     <= 4'h0;
    end else begin
      active_prev <= active;
      for (int i = 0; i < 4; i++) begin
        if (mode[i]) pending[i] <= (active[i] & ~active_prev[i]) | (pending[i] & ~w1c[i]);
        else         pending[i] <= active[i];
      end
      ext_int <= pending & enable;
    end
  end

endmodule

// File: tb/tb_asrm_irq_ctrl.sv
// Directed bench for asrm_irq_ctrl: register table plus edge, filter, level and collision sequences.
module tb_asrm_irq_ctrl;

  localparam logic [15:0] B = 16'hFF00;

  logic        clk;
  logic        reset;
  logic [3:0]  irq_in;
  logic [15:0] addr;
  logic [15:0] bus_wdata;
  logic        write_en;
  logic [15:0] bus_rdata;
  logic        bus_sel;
  logic [3:0]  ext_int;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [15:0] a;
    logic        we;
    logic [15:0] wd;
    logic        sel;
    logic [15:0] rd;
  } vec_t;

  vec_t vecs [17];

  asrm_irq_ctrl dut (
    .clk(clk), .reset(reset), .irq_in(irq_in), .addr(addr),
    .bus_wdata(bus_wdata), .write_en(write_en), .bus_rdata(bus_rdata),
    .bus_sel(bus_sel), .ext_int(ext_int)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] a, input logic we, input logic [15:0] wd);
    addr      = a;
    write_en  = we;
    bus_wdata = wd;
  endtask

  task automatic writeReg(input logic [15:0] offs, input logic [15:0] data);
    applyStimulus(B + offs, 1'b1, data);
    tick();
    write_en = 1'b0;
  endtask

  task automatic readReg(input logic [15:0] offs);
    applyStimulus(B + offs, 1'b0, 16'h0);
    #1;
  endtask

  initial begin
    vecs[0]  = '{B + 16'd2, 1'b0, 16'h0000, 1'b1, 16'h000F};
    vecs[1]  = '{B + 16'd0, 1'b0, 16'h0000, 1'b1, 16'h0000};
    vecs[2]  = '{B + 16'd1, 1'b0, 16'h0000, 1'b1, 16'h0000};
    vecs[3]  = '{B + 16'd1, 1'b1, 16'h000A, 1'b1, 16'h0000};
    vecs[4]  = '{B + 16'd1, 1'b0, 16'h0000, 1'b1, 16'h000A};
    vecs[5]  = '{B + 16'd5, 1'b0, 16'h0000, 1'b0, 16'h0000};
    vecs[6]  = '{16'hFEFF,  1'b0, 16'h0000, 1'b0, 16'h0000};
    vecs[7]  = '{B + 16'd1, 1'b1, 16'hFFF5, 1'b1, 16'h000A};
    vecs[8]  = '{B + 16'd1, 1'b0, 16'h0000, 1'b1, 16'h0005};
    vecs[9]  = '{B + 16'd2, 1'b1, 16'hFFFF, 1'b1, 16'h000F};
    vecs[10] = '{B + 16'd2, 1'b0, 16'h0000, 1'b1, 16'h000F};
    vecs[11] = '{B + 16'd4, 1'b1, 16'h000F, 1'b1, 16'h0000};
    vecs[12] = '{B + 16'd4, 1'b0, 16'h0000, 1'b1, 16'h0000};
    vecs[13] = '{B + 16'd5, 1'b1, 16'h0000, 1'b0, 16'h0000};
    vecs[14] = '{B + 16'd1, 1'b0, 16'h0000, 1'b1, 16'h0005};
    vecs[15] = '{B + 16'd3, 1'b1, 16'h0000, 1'b1, 16'h0000};
    vecs[16] = '{16'hFFFF,  1'b0, 16'h0000, 1'b0, 16'h0000};

    reset = 1'b0; irq_in = 4'h0; addr = 16'h0; bus_wdata = 16'h0; write_en = 1'b0;
    repeat (3) tick();
    checkOutput("init_ext_int", {12'h0, ext_int}, 16'h0000);
    reset = 1'b1;
    tick();

    // Register map table
    for (int i = 0; i < 17; i++) begin
      applyStimulus(vecs[i].a, vecs[i].we, vecs[i].wd);
      #1;
      checkOutput($sformatf("vec%0d_sel", i), {15'h0, bus_sel}, {15'h0, vecs[i].sel});
      checkOutput($sformatf("vec%0d_rdata", i), bus_rdata, vecs[i].rd);
      tick();
      write_en = 1'b0;
    end

    // Edge path latency
    writeReg(16'd1, 16'h0001);
    readReg(16'd0);
    irq_in[0] = 1'b1;
    repeat (5) tick();
    checkOutput("edge_pend_e5", bus_rdata, 16'h0000);
    tick();
    checkOutput("edge_pend_e6", bus_rdata, 16'h0001);
    checkOutput("edge_ext_e6", {12'h0, ext_int}, 16'h0000);
    tick();
    checkOutput("edge_ext_e7", {12'h0, ext_int}, 16'h0001);
    repeat (3) tick();
    irq_in[0] = 1'b0;
    repeat (8) tick();
    checkOutput("edge_ext_held", {12'h0, ext_int}, 16'h0001);
    writeReg(16'd0, 16'h0001);
    checkOutput("edge_w1c_pend", bus_rdata, 16'h0000);
    tick();
    checkOutput("edge_w1c_ext", {12'h0, ext_int}, 16'h0000);

    // Glitch filter
    writeReg(16'd1, 16'h000F);
    readReg(16'd4);
    begin
      logic seen;
      seen = 1'b0;
      irq_in[1] = 1'b1;
      tick(); seen |= bus_rdata[1];
      tick(); seen |= bus_rdata[1];
      irq_in[1] = 1'b0;
      for (int i = 0; i < 8; i++) begin
        tick();
        seen |= bus_rdata[1];
      end
      checkOutput("glitch_level", {15'h0, seen}, 16'h0000);
    end
    readReg(16'd0);
    checkOutput("glitch_pend", bus_rdata, 16'h0000);
    irq_in[1] = 1'b1;
    repeat (4) tick();
    irq_in[1] = 1'b0;
    repeat (8) tick();
    checkOutput("long_pulse_pend", bus_rdata, 16'h0002);
    writeReg(16'd0, 16'h0002);
    checkOutput("long_pulse_w1c", bus_rdata, 16'h0000);

    // Level mode with active-low line 2
    writeReg(16'd2, 16'h000B);
    writeReg(16'd3, 16'h0004);
    readReg(16'd0);
    tick();
    checkOutput("level_pend_set", bus_rdata, 16'h0004);
    writeReg(16'd0, 16'h0004);
    checkOutput("level_w1c_held", bus_rdata, 16'h0004);
    irq_in[2] = 1'b1;
    repeat (5) tick();
    checkOutput("level_pend_e5", bus_rdata, 16'h0004);
    tick();
    checkOutput("level_pend_e6", bus_rdata, 16'h0000);
    irq_in[2] = 1'b0;
    repeat (8) tick();
    writeReg(16'd3, 16'h0000);
    tick();
    writeReg(16'd2, 16'h000F);
    readReg(16'd0);
    checkOutput("level_restore", bus_rdata, 16'h0000);

    // Edge set and W1C on the same clock edge
    irq_in[3] = 1'b1;
    repeat (5) tick();
    applyStimulus(B, 1'b1, 16'h0008);
    tick();
    write_en = 1'b0;
    checkOutput("collide_set_wins", bus_rdata, 16'h0008);
    writeReg(16'd0, 16'h0008);
    checkOutput("collide_w1c", bus_rdata, 16'h0000);

    // Reset asserted mid-stream
    irq_in = 4'hF;
    writeReg(16'd1, 16'h000F);
    repeat (10) tick();
    checkOutput("pre_reset_ext", {12'h0, ext_int}, 16'h0007);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("rst_ext_int", {12'h0, ext_int}, 16'h0000);
    readReg(16'd0);
    checkOutput("rst_pending", bus_rdata, 16'h0000);
    readReg(16'd2);
    checkOutput("rst_mode", bus_rdata, 16'h000F);
    repeat (3) tick();
    readReg(16'd4);
    checkOutput("rst_level", bus_rdata, 16'h0000);
    checkOutput("rst_ext_held", {12'h0, ext_int}, 16'h0000);
    reset = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/asrm_irq_ctrl.md
Name: asrm_irq_ctrl

Overview:
- External interrupt request controller; sits directly upstream of the CPU core's `ext_int[3:0]` input.
- Per line: synchronises raw request pins, glitch-filters them, applies polarity, and latches edge- or level-mode pending bits.
- Drives masked pending requests to the core as `ext_int`.
- Memory-mapped on the system bus; the CPU configures it and clears pending bits through normal load/store cycles.

Parameters:
- wordsize, 16, system bus width; must be >= 8
- BASE_ADDR, 16'hFF00, bus address of register offset 0
- SYNC_STAGES, 2, synchroniser flops per line; must be >= 2
- FILTER_LEN, 3, consecutive stable cycles required before the filtered level changes; 0 = filter bypassed

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- irq_in  in  4  raw asynchronous request pins
- addr  in  wordsize  system bus address, driven by CPU
- bus_wdata  in  wordsize  CPU write data (CPU `data_out`)
- write_en  in  1  CPU bus write strobe
- bus_rdata  out  wordsize  register read data, combinational
- bus_sel  out  1  high when `addr` is in BASE_ADDR..BASE_ADDR+4; the bus mux uses it to route `bus_rdata` to the CPU `data_in`
- ext_int  out  4  registered interrupt requests to the CPU core

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (port `reset`). Reset-low state: sync flops 0, filter counters 0, filtered levels 0, active_prev 0, PENDING 0, ENABLE 0, MODE 4'hF (all edge), POLARITY 0, ext_int 0. Assertion mid-operation clears all of these immediately; any in-flight request is lost.
- Register map (full-width address compare; bits [3:0] only, upper bits read 0, writes to them ignored):
  - +0 PENDING: read; write-1-to-clear
  - +1 ENABLE: read/write
  - +2 MODE: read/write; 1 = edge, 0 = level
  - +3 POLARITY: read/write; 1 = active-low pin
  - +4 LEVEL: read-only; current `active` vector; writes ignored
  - Reads outside these offsets: bus_sel=0 and bus_rdata=0.
- Writes take effect at the posedge where write_en=1 and the address matches. `bus_sel` does not depend on write_en.
- Synchroniser: SYNC_STAGES-deep shift per line; `synced` is the last stage.
- Filter, per line (FILTER_LEN > 0):
  - Saturating counter of width clog2(FILTER_LEN+1).
  - If synced == filtered, the counter clears.
  - Otherwise it increments; on the edge where it reaches FILTER_LEN, `filtered` takes `synced` and the counter clears.
  - FILTER_LEN = 0: `filtered` = `synced` combinationally.
- Active level: active = filtered XOR POLARITY. active_prev <= active every cycle.
- Pending, per line:
  - Edge mode: set when active && !active_prev.
  - Level mode: pending <= active each cycle; W1C has no lasting effect while the line is active.
  - Edge mode, same-cycle set and W1C on one line: set wins.
  - Changing MODE or POLARITY does not clear pending. A polarity change that creates a 0->1 active transition counts as an edge.
- Output: ext_int <= PENDING & ENABLE, registered.
- Latency, pin change to ext_int: SYNC_STAGES + FILTER_LEN + 2 edges (default 7). FILTER_LEN=0 gives SYNC_STAGES + 2.
- Glitches shorter than FILTER_LEN synchronised cycles never reach `filtered`.
- Disabled lines still latch PENDING. Setting ENABLE later raises ext_int one edge after the write.

Test Plan:
- Reset values: assert reset low mid-stream with irq_in=4'hF -> ext_int=0, PENDING=0, MODE reads 4'hF, LEVEL=0 while reset held.
- Edge path: ENABLE=4'h1, defaults; pulse irq_in[0] high 10 cycles starting just before edge 0 -> PENDING[0] set at edge 6, ext_int=4'h1 at edge 7 and held after the pin drops; write 0x0001 to +0 -> ext_int=0 one edge later.
- Glitch filter: irq_in[1] high for 2 cycles, then low, ENABLE=4'hF -> PENDING stays 0, LEVEL[1] never 1. Hold high 4 cycles -> PENDING[1]=1.
- Level mode + polarity: MODE=4'hB, POLARITY=4'h4, irq_in[2]=0 -> PENDING[2]=1. W1C 0x0004 while pin low -> PENDING[2] still 1. Pin high -> PENDING[2]=0 after SYNC_STAGES+FILTER_LEN+1 edges.
- Collision: W1C 0x0008 issued on the same edge irq_in[3]'s rising active edge sets PENDING[3] -> PENDING[3]=1.
- Bus decode: addr=BASE_ADDR+5 -> bus_sel=0, bus_rdata=0. addr=BASE_ADDR+1 with ENABLE=4'hA -> bus_sel=1, bus_rdata=16'h000A. Write 0xFFF5 to +1 -> reads 16'h0005.
